// File: rtl/lane_rr_merger.sv
// lane_rr_merger
//   Drains N lane FIFOs into the single PE-side FIFO. Each grant moves one
//   word. A round-robin pointer picks the lane, so no lane starves. Also
//   produces the `drained` qualifier that is combined with the PE sat flag.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   lane_empty    per-lane empty flags (bit i = lane i)
//   lane_data     lane read data, lane i at [i*W +: W]; valid the cycle after
//                 its rd_req pulse
//   lane_rd_req   registered one-hot read pulse to the granted lane
//   out_full      PE-side FIFO full
//   out_wr_req    registered single-cycle write pulse to the PE-side FIFO
//   out_data      word being written, valid while out_wr_req=1
//   grant_idx     lane currently or last served
//   drained       all lanes empty, FSM idle, no write in flight
//
// Build option
//   LANE_RR_MERGER_STATS_EN adds two outputs:
//     words_merged  32-bit wrapping count of out_wr_req pulses
//     stall_cycles  16-bit saturating count of idle cycles in which a lane
//                   has data but out_full blocks the grant
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | wait for a non-empty lane, room downstream, no write in flight
// ST_READ  | read pulse to the granted lane is on the wire
// ST_WRITE | lane word is on lane_data; write it out, or hold while full

module lane_rr_merger #(
  parameter int N  = 20,
  parameter int W  = 36,
  parameter int IW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   lane_empty,
  input  logic [N*W-1:0] lane_data,
  output logic [N-1:0]   lane_rd_req,
  input  logic           out_full,
  output logic           out_wr_req,
  output logic [W-1:0]   out_data,
  output logic [IW-1:0]  grant_idx,
  output logic           drained
`ifdef LANE_RR_MERGER_STATS_EN
  ,
  output logic [31:0]    words_merged,
  output logic [15:0]    stall_cycles
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]  lane_rd_req_q, lane_rd_req_d;
  logic          out_wr_req_q, out_wr_req_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic          held_q, held_d;

  logic [W-1:0]  lane_word [N];
  logic          found;
  logic [IW:0]   cand;
  logic [IW-1:0] sel;

  always_comb begin
    for (int i = 0; i < N; i++) lane_word[i] = lane_data[i*W +: W];
  end

  // Search starts one past the last grant and wraps at N (not 2^IW), so an
  // index >= N is never produced.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && !lane_empty[cand[IW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    lane_rd_req_d = '0;
    out_wr_req_d  = 1'b0;
    out_data_d    = out_data_q;
    grant_idx_d   = grant_idx_q;
    held_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The out_wr_req term adds a one-cycle bubble after each write.
        // This lets out_full reflect that write before the next grant.
        if (found && !out_full && !out_wr_req_q) begin
          lane_rd_req_d[sel] = 1'b1;
          grant_idx_d        = sel;
          rr_ptr_d           = sel;
          state_d            = ST_READ;
        end
      end
      ST_READ: state_d = ST_WRITE;
      ST_WRITE: begin
        // Capture only on the first WRITE cycle. Later full-retry cycles
        // replay the held word, and the lane is not read again.
        if (!held_q) out_data_d = lane_word[grant_idx_q];
        if (out_full) begin
          held_d = 1'b1;
        end else begin
          out_wr_req_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= IW'(N-1);
      lane_rd_req_q <= '0;
      out_wr_req_q  <= 1'b0;
      out_data_q    <= '0;
      grant_idx_q   <= '0;
      held_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      lane_rd_req_q <= lane_rd_req_d;
      out_wr_req_q  <= out_wr_req_d;
      out_data_q    <= out_data_d;
      grant_idx_q   <= grant_idx_d;
      held_q        <= held_d;
    end
  end

  assign lane_rd_req = lane_rd_req_q;
  assign out_wr_req  = out_wr_req_q;
  assign out_data    = out_data_q;
  assign grant_idx   = grant_idx_q;
  assign drained     = (&lane_empty) && (state_q == ST_IDLE) && !out_wr_req_q;

`ifdef LANE_RR_MERGER_STATS_EN
  logic [31:0] words_q, words_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    words_d = words_q + 32'(out_wr_req_q);
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && !(&lane_empty) && out_full && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign words_merged = words_q;
  assign stall_cycles = stall_q;
`else
  // Statistics counters are not built; the merge path is unchanged.
`endif

endmodule
